snn_layer_scheduler: RTL and testbench
======================================

Name: snn_layer_scheduler

Overview:
- Time-multiplexes one shared leaky-integrate datapath across N_NEURONS neurons of a spiking layer.
- Per timestep, for each neuron in turn: leak the stored membrane, fetch and add weights of active inputs, threshold, fire and reset.
- Sits between the input spike bus, an external synchronous weight memory and the next layer.
- Membranes live in an internal register file; the controller owns all sequencing.

Parameters:
- N_NEURONS, 4, neurons served per timestep.
- N_INPUTS, 4, input spike lines (synapses per neuron).
- THRESH, 64, signed 8-bit firing threshold; fire when v >= THRESH.
- REFRACT, 2, timesteps a neuron is held after firing (only with SNN_REFRACTORY_EN).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request one timestep; accepted only in IDLE.
- in_spk  in  N_INPUTS  input spikes; latched on the cycle start is accepted.
- clr_mem  in  1  in IDLE, zero all membranes (and refractory counters) next cycle; ignored otherwise.
- w_rd  out  1  weight read strobe.
- w_addr  out  clog2(N_NEURONS*N_INPUTS)  address = n*N_INPUTS + i.
- w_data  in  8 signed  weight; valid exactly 1 cycle after w_rd.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at timestep end.
- out_spk  out  N_NEURONS  spike vector of the last completed timestep.

Behaviour:
- Reset (rst=0, async): state IDLE; all membranes 0; out_spk, busy, done, w_rd 0; w_addr 0.
- FSM states: IDLE, LEAK, ACCUM, FIRE, DONE.
- IDLE -> LEAK on start (latch in_spk; n=0; busy=1). start while busy is ignored, not queued. clr_mem has priority over start if both are high in IDLE: clear, stay IDLE.
- LEAK (1 cycle): v <= (v>>>1)+(v>>>2), arithmetic shift. Issue w_rd for i=0.
- ACCUM (N_INPUTS cycles):
  - w_rd/w_addr advance one input per cycle; w_rd is high on the first N_INPUTS-1 of these cycles.
  - Each cycle adds the w_data returned for the previous address only if the latched in_spk[i] is 1.
  - Add saturates to [-128,127]. All weights are fetched regardless of spikes, giving deterministic timing.
- FIRE (1 cycle): if v >= THRESH, set spike bit n and v <= 0.
  - If n < N_NEURONS-1: n++ and go to LEAK. Otherwise go to DONE.
- DONE (1 cycle): out_spk <= internal spike vector; done=1; busy=0; go to IDLE. The internal vector is cleared for the next timestep.
- Latency: N_NEURONS*(N_INPUTS+2)+1 cycles from the start-accept edge to the done pulse (25 with defaults).
- out_spk is stable between done pulses; a timestep aborted by reset never updates it.
- Membranes persist across timesteps; only rst or clr_mem clear them.

Optional Feature:
- SNN_REFRACTORY_EN defined:
  - A 2-bit-or-wider per-neuron counter loads REFRACT on fire.
  - While the counter is nonzero: LEAK and ACCUM cycles still run (timing unchanged), but v is forced to 0 and no spike is issued.
  - The counter decrements at that neuron's FIRE cycle.
- Undefined: no counters; a neuron may fire every timestep.

Decomposition:
- Package snn_pkg: membrane width constant (8), state enum, sat_add8 and leak75 functions.
- Sub-module snn_leak_alu: combinational leak / saturating-add / threshold compare, instantiated once as the shared datapath.
- Membrane array and FSM stay in the top module.

Test Plan:
- Defaults, all weights 20, in_spk=4'b1111, one start: every v=80 -> out_spk=4'b1111, all v=0, done exactly 25 cycles after start.
- All weights 10, in_spk=4'b1111:
  - Step 1: v=40, out_spk=0.
  - Step 2: leak gives 30, +40 = 70 -> out_spk=4'b1111.
- Weights -100, two steps, all inputs active: v clamps to -128; step 2 leak -128 -> -96, then clamps -128; no spikes; w_addr sequence 0..15 each step.
- in_spk=4'b0001, weight[n][0]=70, others 100: only input 0 counts -> each neuron fires with v=70, then resets to 0.
- start asserted mid-timestep and clr_mem while busy: both ignored. rst low at cycle 10: busy/done/out_spk immediately 0, FSM IDLE, membranes 0.
- With SNN_REFRACTORY_EN, REFRACT=2, weights 20: out_spk pattern over 4 steps 1111, 0000, 0000, 1111.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the spiking-layer scheduler.
// Membranes are signed 8-bit values; all arithmetic saturates to that range.
package snn_pkg;

  localparam int MEM_W = 8;

  typedef logic signed [MEM_W-1:0] mem_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAK,
    S_ACCUM,
    S_FIRE,
    S_DONE
  } state_t;

  localparam mem_t MEM_MAX = mem_t'(2 ** (MEM_W - 1) - 1);
  localparam mem_t MEM_MIN = mem_t'(-(2 ** (MEM_W - 1)));

  // Overflow shows up as disagreement between the two top bits of the wide sum.
  function automatic mem_t sat_add8(input mem_t a, input mem_t b);
    logic signed [MEM_W:0] s;
    s = {a[MEM_W-1], a} + {b[MEM_W-1], b};
    if (s[MEM_W] != s[MEM_W-1]) return s[MEM_W] ? MEM_MIN : MEM_MAX;
    return s[MEM_W-1:0];
  endfunction

  // 0.75 leak; the two shifted terms can never overflow the membrane width.
  function automatic mem_t leak75(input mem_t v);
    return (v >>> 1) + (v >>> 2);
  endfunction

endpackage

// File: rtl/snn_leak_alu.sv
// Shared combinational datapath: leak, gated saturating add and threshold compare.
module snn_leak_alu
  import snn_pkg::*;
#(
  parameter logic signed [MEM_W-1:0] THRESH = 8'sd64
) (
  input  logic signed [MEM_W-1:0] v,
  input  logic signed [MEM_W-1:0] w,
  input  logic                    add_en,
  output logic signed [MEM_W-1:0] leak_v,
  output logic signed [MEM_W-1:0] acc_v,
  output logic                    fire
);

  assign leak_v = leak75(v);
  assign acc_v  = add_en ? sat_add8(v, w) : v;
  assign fire   = (v >= THRESH);

endmodule

// File: rtl/snn_layer_scheduler.sv
// Time-multiplexed leaky-integrate-and-fire layer controller with membrane register file.
// Define SNN_REFRACTORY_EN to hold each neuron silent for REFRACT timesteps after it fires.
module snn_layer_scheduler
  import snn_pkg::*;
#(
  parameter int                      N_NEURONS = 4,
  parameter int                      N_INPUTS  = 4,
  parameter logic signed [MEM_W-1:0] THRESH    = 8'sd64,
  parameter int                      REFRACT   = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [N_INPUTS-1:0]                     in_spk,
  input  logic                                    clr_mem,
  output logic                                    w_rd,
  output logic [$clog2(N_NEURONS*N_INPUTS)-1:0]   w_addr,
  input  logic signed [MEM_W-1:0]                 w_data,
  output logic                                    busy,
  output logic                                    done,
  output logic [N_NEURONS-1:0]                    out_spk
);

  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [NW-1:0] N_LAST = NW'(N_NEURONS - 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_INPUTS - 1);

  state_t                   state;
  logic [NW-1:0]            n;
  logic [IW-1:0]            i;
  logic [N_INPUTS-1:0]      spk_lat;
  logic [N_NEURONS-1:0]     spk_vec;
  logic signed [MEM_W-1:0]  mem [N_NEURONS];
  logic signed [MEM_W-1:0]  leak_v, acc_v;
  logic                     fire;
  logic                     held;

  snn_leak_alu #(.THRESH(THRESH)) u_alu (
    .v      (mem[n]),
    .w      (w_data),
    .add_en (spk_lat[i]),
    .leak_v (leak_v),
    .acc_v  (acc_v),
    .fire   (fire)
  );

`ifdef SNN_REFRACTORY_EN
  localparam int RW = ($clog2(REFRACT + 1) > 2) ? $clog2(REFRACT + 1) : 2;
  logic [RW-1:0] refr [N_NEURONS];

  assign held = (refr[n] != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_NEURONS; k++) refr[k] <= '0;
    end else if (state == S_IDLE && clr_mem) begin
      for (int k = 0; k < N_NEURONS; k++) refr[k] <= '0;
    end else if (state == S_FIRE) begin
      if (held)      refr[n] <= refr[n] - 1'b1;
      else if (fire) refr[n] <= RW'(REFRACT);
    end
  end
`else
  assign held = 1'b0;
`endif

  // NOTE: all state below is sequential, so every assignment is non-blocking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      n       <= '0;
      i       <= '0;
      spk_lat <= '0;
      spk_vec <= '0;
      out_spk <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      w_rd    <= 1'b0;
      w_addr  <= '0;
      // NOTE: the membrane file is small and must read as zero after reset, so it is reset explicitly.
      for (int k = 0; k < N_NEURONS; k++) mem[k] <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (clr_mem) begin
            for (int k = 0; k < N_NEURONS; k++) mem[k] <= '0;
          end else if (start) begin
            spk_lat <= in_spk;
            n       <= '0;
            i       <= '0;
            busy    <= 1'b1;
            w_rd    <= 1'b1;
            w_addr  <= '0;
            state   <= S_LEAK;
          end
        end
        S_LEAK: begin
          mem[n] <= held ? '0 : leak_v;
          i      <= '0;
          w_rd   <= (N_INPUTS > 1);
          if (N_INPUTS > 1) w_addr <= w_addr + 1'b1;
          state  <= S_ACCUM;
        end
        S_ACCUM: begin
          mem[n] <= held ? '0 : acc_v;
          // Weight addresses are contiguous across neurons, so the address just counts up.
          w_rd   <= (int'(i) + 2 < N_INPUTS);
          if (int'(i) + 2 < N_INPUTS) w_addr <= w_addr + 1'b1;
          if (i == I_LAST) state <= S_FIRE;
          else             i     <= i + 1'b1;
        end
        S_FIRE: begin
          if (held) begin
            mem[n] <= '0;
          end else if (fire) begin
            spk_vec[n] <= 1'b1;
            mem[n]     <= '0;
          end
          if (n == N_LAST) begin
            state <= S_DONE;
          end else begin
            n      <= n + 1'b1;
            w_rd   <= 1'b1;
            w_addr <= w_addr + 1'b1;
            state  <= S_LEAK;
          end
        end
        S_DONE: begin
          out_spk <= spk_vec;
          spk_vec <= '0;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_layer_scheduler.sv
// Randomised bench for snn_layer_scheduler against a timestep-level reference model.
module tb_snn_layer_scheduler;

  localparam int NN   = 4;
  localparam int NI   = 4;
  localparam int THR  = 64;
  localparam int REFR = 2;
  localparam int LAT  = NN * (NI + 2) + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                clr_mem = 1'b0;
  logic [NI-1:0]       in_spk = '0;
  logic                w_rd;
  logic [3:0]          w_addr;
  logic signed [7:0]   w_data;
  logic                busy;
  logic                done;
  logic [NN-1:0]       out_spk;

  always #5 clk = ~clk;

  snn_layer_scheduler #(
    .N_NEURONS (NN),
    .N_INPUTS  (NI),
    .THRESH    (8'sd64),
    .REFRACT   (REFR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_spk  (in_spk),
    .clr_mem (clr_mem),
    .w_rd    (w_rd),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .busy    (busy),
    .done    (done),
    .out_spk (out_spk)
  );

  // External synchronous weight memory: data one cycle after the read strobe.
  logic signed [7:0] wmem [NN*NI];
  always @(posedge clk) if (w_rd) w_data <= wmem[w_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: membranes, refractory counts and last published spikes.
  int            mv   [NN];
  int            mref [NN];
  logic [NN-1:0] m_out;

  function automatic int fdiv(input int a, input int b);
    return (a < 0 && a % b != 0) ? a / b - 1 : a / b;
  endfunction

  function automatic int clamp8(input int x);
    return (x > 127) ? 127 : (x < -128) ? -128 : x;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NN; k++) begin
      mv[k]   = 0;
      mref[k] = 0;
    end
  endtask

  task automatic model_step(input logic [NI-1:0] spk);
    int v;
    logic [NN-1:0] s;
    s = '0;
    for (int n = 0; n < NN; n++) begin
      v = fdiv(mv[n], 2) + fdiv(mv[n], 4);
      for (int i = 0; i < NI; i++)
        if (spk[i]) v = clamp8(v + int'(wmem[n*NI+i]));
`ifdef SNN_REFRACTORY_EN
      if (mref[n] > 0) begin
        v = 0;
        mref[n]--;
      end else
`endif
      if (v >= THR) begin
        s[n] = 1'b1;
        v    = 0;
`ifdef SNN_REFRACTORY_EN
        mref[n] = REFR;
`endif
      end
      mv[n] = v;
    end
    m_out = s;
  endtask

  task automatic check_mems(input string tag);
    for (int k = 0; k < NN; k++)
      check($sformatf("%s_v%0d", tag, k), int'(dut.mem[k]), mv[k]);
  endtask

  task automatic fill_const(input int w);
    for (int k = 0; k < NN*NI; k++) wmem[k] = 8'(w);
  endtask

  task automatic fill_random();
    for (int k = 0; k < NN*NI; k++) wmem[k] = 8'(int'($urandom_range(0, 90)) - 30);
  endtask

  task automatic clear_idle();
    @(negedge clk);
    clr_mem = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    clr_mem = 1'b0;
    start   = 1'b0;
    model_clear();
    check("clr_prio_busy", busy, 0);
    check_mems("clr");
  endtask

  task automatic run_step(input string tag, input logic [NI-1:0] spk, input bit poke);
    int            cyc;
    int            addrs[$];
    logic [NN-1:0] prev_out;
    bit            stable;
    bit            ok;
    prev_out = m_out;
    stable   = 1'b1;
    @(negedge clk);
    start  = 1'b1;
    in_spk = spk;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    in_spk = ~spk;
    model_step(spk);
    check({tag, "_busy"}, busy, 1);
    cyc = 0;
    while (1) begin
      if (w_rd) addrs.push_back(int'(w_addr));
      if (done) break;
      if (out_spk !== prev_out) stable = 1'b0;
      if (cyc >= 3 * LAT) begin
        check({tag, "_done_timeout"}, cyc, LAT);
        break;
      end
      if (poke && cyc == 5) begin
        start   = 1'b1;
        clr_mem = 1'b1;
      end else begin
        start   = 1'b0;
        clr_mem = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    start   = 1'b0;
    clr_mem = 1'b0;
    check({tag, "_latency"}, cyc, LAT);
    check({tag, "_out_spk"}, out_spk, m_out);
    check({tag, "_out_stable"}, stable, 1);
    check({tag, "_rd_count"}, addrs.size(), NN*NI);
    ok = 1'b1;
    foreach (addrs[k]) if (addrs[k] != k) ok = 1'b0;
    check({tag, "_addr_seq"}, ok, 1);
    check_mems(tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    fill_const(20);
    model_clear();
    m_out = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out", out_spk, 0);
    check("rst_wrd", w_rd, 0);
    check("rst_waddr", w_addr, 0);
    check_mems("rst");
    rst = 1'b1;

    run_step("w20", 4'b1111, 1'b0);

    clear_idle();
    fill_const(10);
    run_step("w10_a", 4'b1111, 1'b0);
    run_step("w10_b", 4'b1111, 1'b0);

    clear_idle();
    fill_const(-100);
    run_step("neg_a", 4'b1111, 1'b0);
    run_step("neg_b", 4'b1111, 1'b0);

    clear_idle();
    for (int k = 0; k < NN*NI; k++) wmem[k] = (k % NI == 0) ? 8'sd70 : 8'sd100;
    run_step("in0", 4'b0001, 1'b0);
    run_step("poke", 4'b0001, 1'b1);

    clear_idle();
    fill_const(20);
    for (int s = 0; s < 4; s++) run_step($sformatf("seq%0d", s), 4'b1111, 1'b0);

    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 5) == 0) clear_idle();
      if ($urandom_range(0, 2) == 0) fill_random();
      run_step($sformatf("rnd%0d", it), 4'($urandom), (it % 5) == 0);
    end

    // Reset in the middle of a timestep.
    fill_random();
    @(negedge clk);
    start  = 1'b1;
    in_spk = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    model_clear();
    m_out = '0;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_out", out_spk, 0);
    check("arst_wrd", w_rd, 0);
    check_mems("arst");
    repeat (2) @(negedge clk);
    check("arst_idle", busy, 0);
    rst = 1'b1;
    run_step("recover", 4'b1011, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
